// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master issues start/a/b; the slave returns busy/done/diff/borrow.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock.
// diff/borrow are registered and only change on the completion edge.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  serial_subtractor_if.slave  s_if
);
  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_bin;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;

  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor cell on the current LSBs and running borrow.
  assign w_a0       = r_a[0];
  assign w_b0       = r_b[0];
  assign w_d        = w_a0 ^ w_b0 ^ r_bin;
  assign w_bout     = (~w_a0 & w_b0) | (~w_a0 & r_bin) | (w_b0 & r_bin);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  assign s_if.busy   = r_busy;
  assign s_if.done   = r_done;
  assign s_if.diff   = r_diff;
  assign s_if.borrow = r_borrow;

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_bin    <= 1'b0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (s_if.start) begin
            r_a     <= s_if.a;
            r_b     <= s_if.b;
            r_res   <= '0;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_res <= w_res_next;
          r_bin <= w_bout;
          r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          if (r_cnt == LAST) begin
            r_diff   <= w_res_next;
            r_borrow <= w_bout;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_state  <= S_SHIFT;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  serial_subtractor_if #(.WIDTH(8)) u_if ();

  serial_subtractor #(.WIDTH(8)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .s_if  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one op, verify busy over 8 cycles, the done pulse and held result.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_diff, input logic exp_borrow);
    u_if.start = 1'b1;
    u_if.a     = a;
    u_if.b     = b;
    tick();
    u_if.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy"}, {31'd0, u_if.busy}, 32'd1);
      check({tag, "_nodone"}, {31'd0, u_if.done}, 32'd0);
      tick();
    end
    check({tag, "_done"}, {31'd0, u_if.done}, 32'd1);
    check({tag, "_busy_off"}, {31'd0, u_if.busy}, 32'd0);
    check({tag, "_diff"}, {24'd0, u_if.diff}, {24'd0, exp_diff});
    check({tag, "_borrow"}, {31'd0, u_if.borrow}, {31'd0, exp_borrow});
    tick();
    check({tag, "_done_pulse"}, {31'd0, u_if.done}, 32'd0);
    check({tag, "_diff_hold"}, {24'd0, u_if.diff}, {24'd0, exp_diff});
    check({tag, "_borrow_hold"}, {31'd0, u_if.borrow}, {31'd0, exp_borrow});
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] md;
    logic       mb;
    int         pulses;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    u_if.start = 1'b0;
    u_if.a     = 8'd0;
    u_if.b     = 8'd0;
    tick();
    tick();
    check("rst_busy", {31'd0, u_if.busy}, 32'd0);
    check("rst_done", {31'd0, u_if.done}, 32'd0);
    check("rst_diff", {24'd0, u_if.diff}, 32'd0);
    check("rst_borrow", {31'd0, u_if.borrow}, 32'd0);
    rst = 1'b0;
    tick();

    run_op("5m3", 8'd5, 8'd3, 8'h02, 1'b0);
    run_op("3m5", 8'd3, 8'd5, 8'hFE, 1'b1);
    run_op("0m1", 8'd0, 8'd1, 8'hFF, 1'b1);
    run_op("0m0", 8'd0, 8'd0, 8'h00, 1'b0);
    run_op("FFmFF", 8'hFF, 8'hFF, 8'h00, 1'b0);
    run_op("80m7F", 8'h80, 8'h7F, 8'h01, 1'b0);

    // start and operand changes during SHIFT must be ignored
    u_if.start = 1'b1; u_if.a = 8'd5; u_if.b = 8'd3;
    tick();
    u_if.start = 1'b0;
    pulses = 0;
    tick(); tick(); tick();
    u_if.start = 1'b1; u_if.a = 8'd9; u_if.b = 8'd1;
    tick();
    u_if.a = 8'hAA; u_if.b = 8'h55;
    tick();
    u_if.a = 8'd3; u_if.b = 8'd200;
    tick();
    u_if.start = 1'b0; u_if.a = 8'd77; u_if.b = 8'd12;
    tick();
    check("ign_busy_e7", {31'd0, u_if.busy}, 32'd1);
    tick();
    check("ign_diff", {24'd0, u_if.diff}, 32'h02);
    check("ign_borrow", {31'd0, u_if.borrow}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      if (u_if.done) pulses++;
      tick();
    end
    check("ign_one_done", pulses, 32'd1);
    check("ign_idle", {31'd0, u_if.busy}, 32'd0);

    // back-to-back: second op accepted in the DONE cycle
    u_if.start = 1'b1; u_if.a = 8'd3; u_if.b = 8'd5;
    tick();
    u_if.a = 8'd10; u_if.b = 8'd4;
    for (int i = 0; i < 8; i++) tick();
    check("b2b_done1", {31'd0, u_if.done}, 32'd1);
    check("b2b_diff1", {24'd0, u_if.diff}, 32'hFE);
    check("b2b_borrow1", {31'd0, u_if.borrow}, 32'd1);
    tick();
    u_if.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("b2b_busy2", {31'd0, u_if.busy}, 32'd1);
      check("b2b_diff_hold", {24'd0, u_if.diff}, 32'hFE);
      tick();
    end
    check("b2b_done2", {31'd0, u_if.done}, 32'd1);
    check("b2b_diff2", {24'd0, u_if.diff}, 32'h06);
    check("b2b_borrow2", {31'd0, u_if.borrow}, 32'd0);
    tick();

    // reset during SHIFT aborts with no done pulse
    run_op("pre_abort", 8'd5, 8'd3, 8'h02, 1'b0);
    u_if.start = 1'b1; u_if.a = 8'd200; u_if.b = 8'd100;
    tick();
    u_if.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, u_if.busy}, 32'd0);
    check("abort_done", {31'd0, u_if.done}, 32'd0);
    check("abort_diff", {24'd0, u_if.diff}, 32'd0);
    check("abort_borrow", {31'd0, u_if.borrow}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (u_if.done) pulses++;
      tick();
    end
    check("abort_no_done", pulses, 32'd0);
    run_op("7m7", 8'd7, 8'd7, 8'h00, 1'b0);

    // randomized sweep against a reference model
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(255, 0));
      rb = 8'($urandom_range(255, 0));
      md = 8'((int'(ra) - int'(rb) + 256) % 256);
      mb = (ra < rb) ? 1'b1 : 1'b0;
      u_if.start = 1'b1; u_if.a = ra; u_if.b = rb;
      tick();
      u_if.start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("rnd_done", {31'd0, u_if.done}, 32'd1);
      check("rnd_diff", {24'd0, u_if.diff}, {24'd0, md});
      check("rnd_borrow", {31'd0, u_if.borrow}, {31'd0, mb});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor computing diff = a - b, LSB first, one bit per clock.
- Each step uses full-subtractor logic (difference plus borrow-out), the inverse of the team's full-adder cell.
- Used where area matters more than latency.
- Start/busy/done handshake; result and final borrow are registered and held until the next completion.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new subtraction; sampled only when accepted (see handshake).
- a  input  WIDTH  minuend; captured on the accept edge.
- b  input  WIDTH  subtrahend; captured on the accept edge.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse: diff and borrow are newly valid.
- diff  output  WIDTH  registered difference (a - b) mod 2^WIDTH.
- borrow  output  1  registered final borrow-out; 1 exactly when a < b (unsigned).

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, diff=0, borrow=0, bit counter=0, internal shift and borrow registers=0.
  - Reset overrides all other inputs and aborts any operation in progress; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1: accept; latch a and b into shift registers, clear the running borrow (bin=0), clear counter, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - busy=1.
  - Each edge takes a0 = LSB of the a-shift register and b0 = LSB of the b-shift register.
  - d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~a0 & bin) | (b0 & bin).
  - d shifts into the MSB of the result shift register (shift right); a/b shift registers shift right; bin <= bout; counter increments.
  - On the edge processing bit WIDTH-1: load diff <= completed result, borrow <= bout, go to DONE.
  - start is ignored in SHIFT; a and b may change freely without effect.
- DONE:
  - busy=0, done=1 for this single cycle.
  - If start=1: accept a new operation exactly as in IDLE and go to SHIFT (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- Latency: done is high in the cycle following the WIDTH-th edge after the accept edge. busy is high for exactly WIDTH cycles per operation.
- diff/borrow change only on the completion edge. They hold their previous values through a subsequent accept and SHIFT phase.
- Arithmetic: modulo 2^WIDTH. diff equals a + ~b + 1 truncated to WIDTH; borrow is the inverse of that sum's carry-out.
- Counter width: $clog2(WIDTH) bits, compared against WIDTH-1. No wrap-around dependence.

Test Plan:
- WIDTH=8, a=5, b=3, start pulse for 1 cycle -> busy high 8 cycles, then done=1 for 1 cycle, diff=8'h02, borrow=0; both held afterwards.
- a=3, b=5 -> diff=8'hFE, borrow=1. Also a=0, b=1 -> diff=8'hFF, borrow=1.
- a=0, b=0 -> diff=0, borrow=0. Also a=8'hFF, b=8'hFF -> diff=0, borrow=0. Also a=8'h80, b=8'h7F -> diff=8'h01, borrow=0.
- Start 5-3; after 3 SHIFT cycles assert start with a=9, b=1, and change a/b repeatedly -> ignored; result still diff=2, borrow=0, exactly one done pulse.
- Start 3-5 and hold start=1 with a=10, b=4 through the DONE cycle -> first done gives diff=FE, borrow=1. Second op is accepted in DONE with no idle gap; 8 cycles later done gives diff=06, borrow=0. diff stays FE during the second SHIFT phase.
- Complete 5-3 (diff=2); start 200-100, assert rst in 4th SHIFT cycle -> next cycle busy=0, done=0, diff=0, borrow=0, IDLE; no done pulse. Then 7-7 -> diff=0, borrow=0, correct timing.
- Randomized sweep of 1000 (a,b) pairs against a reference model: diff == (a-b) mod 256, borrow == (a<b).
